// File: rtl/flashattn_tile_sequencer_pkg.sv
// Shared state encoding and error codes for the flashattn tile sequencer.
package flashattn_seq_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    REQ_Q   = 4'd2,
    LOAD_Q  = 4'd3,
    REQ_KV  = 4'd4,
    LOAD_KV = 4'd5,
    DRAIN_O = 4'd6,
    NEXT    = 4'd7,
    ERR     = 4'd8
  } seq_state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_STALL      = 2'd1;
  localparam logic [1:0] ERR_OVERRUN    = 2'd2;
  localparam logic [1:0] ERR_EARLY_DONE = 2'd3;

endpackage

// File: rtl/flashattn_tile_sequencer_stall_watchdog.sv
// Counts consecutive stalled cycles with no stream progress; flags a deadlock at the limit.
module flashattn_stall_watchdog #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic enable,
  input  logic clear,
  input  logic stall_any,
  input  logic beat_any,
  output logic timeout
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

  logic [SW-1:0] stall_cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if (!enable || clear || beat_any) begin
      stall_cnt <= '0;
    end else if (stall_any && (stall_cnt != LIMIT)) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign timeout = enable && (stall_cnt == LIMIT);

endmodule

// File: rtl/flashattn_tile_sequencer.sv
// Runs the flashattn kernel over a sequence of Q tiles: ap_ctrl start, Q and K/V DMA
// requests, AXIS beat accounting, and overrun / early-done / stall error detection.
module flashattn_tile_sequencer
  import flashattn_seq_pkg::*;
#(
  parameter int NUM_KV_TILES = 4,
  parameter int Q_BEATS      = 16,
  parameter int KV_BEATS     = 16,
  parameter int O_BEATS      = 16,
  parameter int STALL_LIMIT  = 1024
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        cfg_start,
  input  logic [15:0] cfg_num_q_tiles,
  input  logic        err_clr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] tiles_done,
  output logic        k_ap_start,
  input  logic        k_ap_ready,
  input  logic        k_ap_done,
  output logic        q_req_valid,
  input  logic        q_req_ready,
  output logic [15:0] q_req_tile,
  output logic        kv_req_valid,
  input  logic        kv_req_ready,
  output logic [15:0] kv_req_tile,
  input  logic        q_beat,
  input  logic        k_beat,
  input  logic        v_beat,
  input  logic        o_beat,
  input  logic        stall_any,
  output logic [3:0]  dbg_state
);

  localparam int QW = $clog2(Q_BEATS + 1);
  localparam int KW = $clog2(KV_BEATS + 1);
  localparam int OW = $clog2(O_BEATS + 1);
  localparam logic [QW-1:0] Q_LIM  = QW'(Q_BEATS);
  localparam logic [KW-1:0] KV_LIM = KW'(KV_BEATS);
  localparam logic [OW-1:0] O_LIM  = OW'(O_BEATS);
  localparam logic [15:0]   KV_LAST = 16'(NUM_KV_TILES - 1);

  seq_state_e state, state_next;
  logic [15:0] num_tiles, kv_idx;
  logic [QW-1:0] q_cnt, q_cnt_inc;
  logic [KW-1:0] k_cnt, k_cnt_inc, v_cnt, v_cnt_inc;
  logic [OW-1:0] o_cnt, o_cnt_inc;
  logic [1:0] err_sel, err_code_q;
  logic in_q, in_kv, in_o, run_active, overrun, early_done, timeout;

  assign in_q       = (state == LOAD_Q);
  assign in_kv      = (state == LOAD_KV);
  assign in_o       = (state == DRAIN_O);
  assign run_active = (state != IDLE) && (state != ERR);
  assign busy       = run_active;
  assign err        = (state == ERR);
  assign err_code   = err_code_q;
  assign dbg_state  = state;
  // Handshakes: k_ap_start is held in START until k_ap_ready (same-cycle counts).
  // q/kv_req_valid rise the cycle after REQ_* entry, keep the tile index stable,
  // and a transfer happens on any cycle where valid and ready are both high.
  assign k_ap_start  = (state == START);
  assign q_req_tile  = tiles_done;
  assign kv_req_tile = kv_idx;

  always_comb begin
    q_cnt_inc  = q_cnt + QW'(q_beat);
    k_cnt_inc  = k_cnt + KW'(k_beat);
    v_cnt_inc  = v_cnt + KW'(v_beat);
    o_cnt_inc  = o_cnt + OW'(o_beat);
    overrun    = 1'b0;
    early_done = 1'b0;
    if (run_active) begin
      overrun = (q_beat && (!in_q  || q_cnt == Q_LIM))  ||
                (k_beat && (!in_kv || k_cnt == KV_LIM)) ||
                (v_beat && (!in_kv || v_cnt == KV_LIM)) ||
                (o_beat && (!in_o  || o_cnt == O_LIM));
      // Done is legal only once this cycle's beat completes the output tile.
      if (in_o) early_done = k_ap_done && (o_cnt_inc < O_LIM);
      else if (state != NEXT) early_done = k_ap_done;
    end
  end

  always_comb begin
    state_next = state;
    err_sel    = ERR_NONE;
    case (state)
      IDLE:    if (cfg_start && (cfg_num_q_tiles != 16'd0)) state_next = START;
      START:   if (k_ap_ready) state_next = REQ_Q;
      REQ_Q:   if (q_req_valid && q_req_ready) state_next = LOAD_Q;
      LOAD_Q:  if (q_cnt_inc == Q_LIM) state_next = REQ_KV;
      REQ_KV:  if (kv_req_valid && kv_req_ready) state_next = LOAD_KV;
      LOAD_KV: if ((k_cnt_inc == KV_LIM) && (v_cnt_inc == KV_LIM))
                 state_next = (kv_idx < KV_LAST) ? REQ_KV : DRAIN_O;
      DRAIN_O: if ((o_cnt_inc == O_LIM) && k_ap_done) state_next = NEXT;
      NEXT:    state_next = ((tiles_done + 16'd1) == num_tiles) ? IDLE : START;
      ERR:     if (err_clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (overrun) begin
      state_next = ERR;
      err_sel    = ERR_OVERRUN;
    end else if (early_done) begin
      state_next = ERR;
      err_sel    = ERR_EARLY_DONE;
    end else if (timeout) begin
      state_next = ERR;
      err_sel    = ERR_STALL;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      num_tiles    <= '0;
      tiles_done   <= '0;
      kv_idx       <= '0;
      q_cnt        <= '0;
      k_cnt        <= '0;
      v_cnt        <= '0;
      o_cnt        <= '0;
      q_req_valid  <= 1'b0;
      kv_req_valid <= 1'b0;
      done         <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state        <= state_next;
      q_cnt        <= (in_q  && state_next == LOAD_Q)  ? q_cnt_inc : '0;
      k_cnt        <= (in_kv && state_next == LOAD_KV) ? k_cnt_inc : '0;
      v_cnt        <= (in_kv && state_next == LOAD_KV) ? v_cnt_inc : '0;
      o_cnt        <= (in_o  && state_next == DRAIN_O) ? o_cnt_inc : '0;
      q_req_valid  <= (state == REQ_Q)  && (state_next == REQ_Q);
      kv_req_valid <= (state == REQ_KV) && (state_next == REQ_KV);
      done         <= ((state == IDLE) && cfg_start && (cfg_num_q_tiles == 16'd0)) ||
                      ((state == NEXT) && (state_next == IDLE));
      if ((state == IDLE) && (state_next == START)) begin
        num_tiles  <= cfg_num_q_tiles;
        tiles_done <= '0;
      end else if ((state == NEXT) && (state_next != ERR)) begin
        tiles_done <= tiles_done + 16'd1;
      end
      if (in_q) kv_idx <= '0;
      else if (in_kv && state_next == REQ_KV) kv_idx <= kv_idx + 16'd1;
      if ((state_next == ERR) && (state != ERR)) err_code_q <= err_sel;
      else if ((state == ERR) && err_clr) err_code_q <= ERR_NONE;
    end
  end

  flashattn_stall_watchdog #(.STALL_LIMIT(STALL_LIMIT)) u_watchdog (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .enable    (in_q || in_kv || in_o),
    .clear     (state_next != state),
    .stall_any (stall_any),
    .beat_any  (q_beat || k_beat || v_beat || o_beat),
    .timeout   (timeout)
  );

endmodule

// File: tb/tb_flashattn_tile_sequencer.sv
// Self-checking bench for flashattn_tile_sequencer: table-driven and random runs against a
// request-order model, plus hand sequences for K/V skew, stall, overrun, early done and reset.
module tb_flashattn_tile_sequencer;

  localparam int NUM_KV = 4;
  localparam int QB     = 16;
  localparam int KVB    = 16;
  localparam int OB     = 16;
  localparam int STALL  = 1024;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_num_q_tiles = '0;
  logic        err_clr = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] tiles_done;
  logic        k_ap_start;
  logic        k_ap_ready = 1'b0;
  logic        k_ap_done = 1'b0;
  logic        q_req_valid;
  logic        q_req_ready = 1'b0;
  logic [15:0] q_req_tile;
  logic        kv_req_valid;
  logic        kv_req_ready = 1'b0;
  logic [15:0] kv_req_tile;
  logic        q_beat = 1'b0, k_beat = 1'b0, v_beat = 1'b0, o_beat = 1'b0;
  logic        stall_any = 1'b0;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  int done_cnt = 0, start_cnt = 0, qvalid_cnt = 0;

  typedef struct {
    int num;
    int gap;
    int done_lag;
    int exp_tiles;
    int exp_done;
  } vec_t;
  vec_t vecs[4];

  flashattn_tile_sequencer dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .cfg_start       (cfg_start),
    .cfg_num_q_tiles (cfg_num_q_tiles),
    .err_clr         (err_clr),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_code        (err_code),
    .tiles_done      (tiles_done),
    .k_ap_start      (k_ap_start),
    .k_ap_ready      (k_ap_ready),
    .k_ap_done       (k_ap_done),
    .q_req_valid     (q_req_valid),
    .q_req_ready     (q_req_ready),
    .q_req_tile      (q_req_tile),
    .kv_req_valid    (kv_req_valid),
    .kv_req_ready    (kv_req_ready),
    .kv_req_tile     (kv_req_tile),
    .q_beat          (q_beat),
    .k_beat          (k_beat),
    .v_beat          (v_beat),
    .o_beat          (o_beat),
    .stall_any       (stall_any),
    .dbg_state       (dbg_state)
  );

  // Clock / global time bound
  always #5 ap_clk = ~ap_clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Scoreboard: every request handshake must match the head of the model queue
  task automatic sb_req(input logic kind, input logic [15:0] tile);
    logic [16:0] got;
    got = {kind, tile};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_req: got kind=%0d tile=%0d, expected no request", kind, tile);
    end else begin
      check("req_order", 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (done) done_cnt++;
      if (k_ap_start) start_cnt++;
      if (q_req_valid) qvalid_cnt++;
      if (q_req_valid && q_req_ready) sb_req(1'b0, q_req_tile);
      if (kv_req_valid && kv_req_ready) sb_req(1'b1, kv_req_tile);
    end
  end

  // Reference model: a run of n tiles requests Q tile t, then K/V tiles 0..NUM_KV-1
  task automatic model_expect(input int num);
    for (int t = 0; t < num; t++) begin
      exp_q.push_back({1'b0, 16'(t)});
      for (int k = 0; k < NUM_KV; k++) exp_q.push_back({1'b1, 16'(k)});
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return k_ap_start;
      1:       return q_req_valid;
      default: return kv_req_valid;
    endcase
  endfunction

  function automatic logic coin(input int gap);
    return (gap == 0) || ($urandom_range(0, gap) == 0);
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n;
    n = 0;
    while (!sel(which) && n < 200) begin
      tick();
      n++;
    end
    if (!sel(which)) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: signal low after %0d cycles, required high", name, n);
    end
  endtask

  // Driver tasks
  task automatic begin_run(input int num);
    cfg_num_q_tiles = 16'(num);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic do_start(input int gap);
    wait_sig(0, "k_ap_start");
    repeat ($urandom_range(0, gap)) tick();
    k_ap_ready = 1'b1;
    tick();
    k_ap_ready = 1'b0;
  endtask

  task automatic do_q_req(input int gap);
    wait_sig(1, "q_req_valid");
    repeat ($urandom_range(0, gap)) tick();
    q_req_ready = 1'b1;
    tick();
    q_req_ready = 1'b0;
  endtask

  task automatic do_kv_req(input int gap);
    wait_sig(2, "kv_req_valid");
    repeat ($urandom_range(0, gap)) tick();
    kv_req_ready = 1'b1;
    tick();
    kv_req_ready = 1'b0;
  endtask

  task automatic send_q(input int gap);
    int sent;
    sent = 0;
    while (sent < QB) begin
      q_beat = coin(gap);
      if (q_beat) sent++;
      tick();
    end
    q_beat = 1'b0;
  endtask

  task automatic send_kv(input int gap, input int lag);
    int ks, vs, c;
    ks = 0; vs = 0; c = 0;
    while (ks < KVB || vs < KVB) begin
      k_beat = (ks < KVB) && coin(gap);
      v_beat = (vs < KVB) && (c >= lag) && coin(gap);
      if (k_beat) ks++;
      if (v_beat) vs++;
      tick();
      c++;
    end
    k_beat = 1'b0;
    v_beat = 1'b0;
  endtask

  task automatic send_o(input int gap, input int done_lag);
    int sent;
    sent = 0;
    while (sent < OB) begin
      o_beat = coin(gap);
      if (o_beat) sent++;
      k_ap_done = o_beat && (sent == OB) && (done_lag == 0);
      tick();
    end
    o_beat = 1'b0;
    k_ap_done = 1'b0;
    if (done_lag > 0) begin
      repeat (done_lag - 1) tick();
      k_ap_done = 1'b1;
      tick();
      k_ap_done = 1'b0;
    end
  endtask

  task automatic run_tile(input int gap, input int done_lag);
    do_start(gap);
    do_q_req(gap);
    send_q(gap);
    for (int k = 0; k < NUM_KV; k++) begin
      do_kv_req(gap);
      send_kv(gap, 0);
    end
    send_o(gap, done_lag);
  endtask

  task automatic full_run(input int num, input int gap, input int done_lag,
                          input int exp_tiles, input int exp_done);
    int d0;
    d0 = done_cnt;
    model_expect(num);
    begin_run(num);
    check("start_latency", 32'(k_ap_start), 32'd1);
    for (int t = 0; t < num; t++) run_tile(gap, done_lag);
    tick();
    tick();
    check("run_tiles_done", 32'(tiles_done), 32'(exp_tiles));
    check("run_done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    check("run_err", 32'(err), 32'd0);
    check("run_idle", 32'(busy), 32'd0);
    check("run_all_reqs_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr_err", 32'(err), 32'd0);
    check("err_clr_code", 32'(err_code), 32'd0);
    check("err_clr_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'({err, err_code}), 32'd0);
    check({name, "_tiles"}, 32'(tiles_done), 32'd0);
    check({name, "_start"}, 32'(k_ap_start), 32'd0);
    check({name, "_valids"}, 32'({q_req_valid, kv_req_valid}), 32'd0);
    check({name, "_req_tiles"}, {q_req_tile, kv_req_tile}, 32'd0);
  endtask

  initial begin
    int s0, q0, num, gap, lag, n;

    vecs[0] = '{num: 1, gap: 0, done_lag: 0, exp_tiles: 1, exp_done: 1};
    vecs[1] = '{num: 2, gap: 0, done_lag: 0, exp_tiles: 2, exp_done: 1};
    vecs[2] = '{num: 3, gap: 2, done_lag: 1, exp_tiles: 3, exp_done: 1};
    vecs[3] = '{num: 2, gap: 1, done_lag: 3, exp_tiles: 2, exp_done: 1};

    // Reset state
    #12;
    check_outputs_zero("reset");
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    tick();

    // Zero tiles
    s0 = start_cnt;
    q0 = qvalid_cnt;
    begin_run(0);
    check("zero_done", 32'(done), 32'd1);
    tick();
    check("zero_done_pulse", 32'(done), 32'd0);
    repeat (5) tick();
    check("zero_no_start", 32'(start_cnt - s0), 32'd0);
    check("zero_no_qreq", 32'(qvalid_cnt - q0), 32'd0);
    check("zero_idle", 32'(busy), 32'd0);

    // Table-driven runs
    foreach (vecs[i]) full_run(vecs[i].num, vecs[i].gap, vecs[i].done_lag,
                               vecs[i].exp_tiles, vecs[i].exp_done);

    // Simultaneous and skewed K/V beats
    model_expect(1);
    begin_run(1);
    do_start(0);
    do_q_req(0);
    send_q(0);
    do_kv_req(0);
    k_beat = 1'b1;
    v_beat = 1'b1;
    repeat (16) tick();
    k_beat = 1'b0;
    v_beat = 1'b0;
    tick();
    check("kv_simul_exit", 32'({kv_req_valid, kv_req_tile}), 32'h1_0001);
    do_kv_req(0);
    for (int c = 0; c < 21; c++) begin
      k_beat = (c < 16);
      v_beat = (c >= 5);
      tick();
    end
    k_beat = 1'b0;
    v_beat = 1'b0;
    tick();
    check("kv_lag_exit", 32'({kv_req_valid, kv_req_tile}), 32'h1_0002);
    for (int k = 2; k < NUM_KV; k++) begin
      do_kv_req(0);
      send_kv(0, 0);
    end
    send_o(0, 0);
    tick();
    tick();
    check("kv_run_tiles", 32'(tiles_done), 32'd1);
    check("kv_run_err", 32'(err), 32'd0);

    // Random runs against the model
    repeat (3) begin
      num = $urandom_range(1, 3);
      gap = $urandom_range(0, 3);
      lag = $urandom_range(0, 4);
      full_run(num, gap, lag, num, 1);
    end

    // Stall timeout in LOAD_KV
    exp_q.push_back({1'b0, 16'd0});
    exp_q.push_back({1'b1, 16'd0});
    begin_run(1);
    do_start(0);
    do_q_req(0);
    send_q(0);
    do_kv_req(0);
    k_beat = 1'b1;
    v_beat = 1'b1;
    repeat (3) tick();
    k_beat = 1'b0;
    v_beat = 1'b0;
    stall_any = 1'b1;
    repeat (STALL - 1) tick();
    check("stall_not_yet", 32'(err), 32'd0);
    n = 0;
    while (!err && n < 4) begin
      tick();
      n++;
    end
    check("stall_err", 32'(err), 32'd1);
    check("stall_code", 32'(err_code), 32'd1);
    check("stall_outputs_off", 32'({busy, k_ap_start, q_req_valid, kv_req_valid}), 32'd0);
    stall_any = 1'b0;
    clear_err();

    // Overrun: a 17th Q beat
    exp_q.push_back({1'b0, 16'd0});
    begin_run(1);
    do_start(0);
    do_q_req(0);
    send_q(0);
    q_beat = 1'b1;
    tick();
    q_beat = 1'b0;
    check("overrun_err", 32'(err), 32'd1);
    check("overrun_code", 32'(err_code), 32'd2);
    clear_err();

    // Early done in LOAD_KV
    exp_q.push_back({1'b0, 16'd0});
    exp_q.push_back({1'b1, 16'd0});
    begin_run(1);
    do_start(0);
    do_q_req(0);
    send_q(0);
    do_kv_req(0);
    k_ap_done = 1'b1;
    tick();
    k_ap_done = 1'b0;
    check("early_done_code", 32'(err_code), 32'd3);
    clear_err();

    // Overrun and early done together: overrun wins
    exp_q.push_back({1'b0, 16'd0});
    begin_run(1);
    do_start(0);
    do_q_req(0);
    send_q(0);
    q_beat = 1'b1;
    k_ap_done = 1'b1;
    tick();
    q_beat = 1'b0;
    k_ap_done = 1'b0;
    check("priority_code", 32'(err_code), 32'd2);
    clear_err();

    // Reset during DRAIN_O, then a fresh run
    model_expect(1);
    begin_run(1);
    do_start(0);
    do_q_req(0);
    send_q(0);
    for (int k = 0; k < NUM_KV; k++) begin
      do_kv_req(0);
      send_kv(0, 0);
    end
    o_beat = 1'b1;
    repeat (5) tick();
    o_beat = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    check("midrun_reqs_seen", 32'(exp_q.size()), 32'd0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    full_run(1, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flashattn_tile_sequencer.md
Name: flashattn_tile_sequencer

Overview:
Top-level scheduler that runs the flashattn HLS kernel over a sequence of Q tiles. For each Q tile it:
- starts the kernel through its ap_ctrl handshake;
- issues DMA requests for the Q tile and for every K/V tile;
- counts AXIS beats on the Q/K/V/O streams to track progress.
A built-in stall watchdog flags stream deadlock in hardware, replacing simulation-only monitoring for silicon runs.

Parameters:
NUM_KV_TILES, 4, K/V tiles consumed per Q tile
Q_BEATS, 16, AXIS beats per Q tile
KV_BEATS, 16, beats per K tile and per V tile (each)
O_BEATS, 16, beats per output tile
STALL_LIMIT, 1024, consecutive stalled cycles before watchdog error (fits 16-bit counter)

Ports:
ap_clk  in  1  single clock, all logic rising-edge
ap_rst_n  in  1  asynchronous, active-low reset
cfg_start  in  1  pulse; latch cfg_num_q_tiles and begin; ignored unless IDLE
cfg_num_q_tiles  in  16  number of Q tiles to process
err_clr  in  1  pulse; leave ERR, return to IDLE
busy  out  1  high in every state except IDLE/ERR
done  out  1  one-cycle pulse at end of run
err  out  1  sticky error flag
err_code  out  2  1=stall timeout, 2=beat overrun, 3=early ap_done
tiles_done  out  16  completed Q tiles this run
k_ap_start  out  1  kernel start
k_ap_ready  in  1  kernel accepted start
k_ap_done  in  1  kernel finished
q_req_valid  out  1  Q DMA request
q_req_ready  in  1
q_req_tile  out  16  Q tile index
kv_req_valid  out  1  K/V DMA request
kv_req_ready  in  1
kv_req_tile  out  16  K/V tile index (0..NUM_KV_TILES-1)
q_beat, k_beat, v_beat, o_beat  in  1 each  TVALID&TREADY of each stream
stall_any  in  1  OR of inverted stream blk_n signals

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE; every output is 0; all counters are 0. Mid-run reset aborts immediately. Outstanding DMA or kernel activity is the system's responsibility.
- IDLE:
  - cfg_start with num=0 -> done pulse next cycle, stay IDLE, no kernel start.
  - cfg_start with num>0 -> latch num, clear tiles_done, go to START.
- START: k_ap_start=1 until k_ap_ready=1 (start and ready high in the same cycle counts as accepted); then REQ_Q.
- REQ_Q: q_req_valid=1 and q_req_tile=tiles_done, held stable until q_req_ready; then LOAD_Q.
- LOAD_Q: count q_beat; when the count reaches Q_BEATS, go to REQ_KV with kv_idx=0.
- REQ_KV: kv_req_valid=1 and kv_req_tile=kv_idx until kv_req_ready; then LOAD_KV.
- LOAD_KV:
  - k_beat and v_beat are counted independently; both may assert in the same cycle.
  - Leave only when both counts equal KV_BEATS.
  - If kv_idx < NUM_KV_TILES-1: kv_idx++ and go to REQ_KV. Otherwise go to DRAIN_O.
- DRAIN_O: count o_beat. Exit when o_cnt==O_BEATS and k_ap_done has been seen; the done flag may arrive the same cycle as, or after, the last beat. Then NEXT.
- NEXT (1 cycle): tiles_done++. If tiles_done==num, go to IDLE with a done pulse on the transition. Otherwise go to START.
- Overrun (err_code=2): any beat while its counter already equals its limit, or a q/k/v/o beat arriving in a state that does not count it.
- Early done (err_code=3): k_ap_done before DRAIN_O, or in DRAIN_O with o_cnt<O_BEATS.
- Watchdog (err_code=1):
  - Active in LOAD_Q, LOAD_KV and DRAIN_O.
  - stall_cnt increments each cycle stall_any=1 with no beat.
  - It clears on any beat or any state change.
  - stall_cnt==STALL_LIMIT raises the error.
- Error priority: 2 > 3 > 1 when several occur in the same cycle.
- Any error -> ERR. In ERR: err=1, err_code held; busy, k_ap_start and all valids are 0; beats are ignored. err_clr -> IDLE and clears err/err_code; cfg_start is ignored in ERR.
- Latency: cfg_start to k_ap_start is 1 cycle. Requests are registered: valid rises the cycle after state entry.
- Counter widths: $clog2(limit+1); tiles_done and kv_idx are 16-bit and do not wrap within a legal run.

Decomposition:
- Package flashattn_seq_pkg holds:
  - state enum (IDLE, START, REQ_Q, LOAD_Q, REQ_KV, LOAD_KV, DRAIN_O, NEXT, ERR);
  - err_code constants (ERR_NONE=0, ERR_STALL=1, ERR_OVERRUN=2, ERR_EARLY_DONE=3).
- One sub-module, flashattn_stall_watchdog, takes stall_any, beat_any, clear and enable, and outputs timeout.

Test Plan:
- Nominal run:
  - Stimulus: num=2, NUM_KV_TILES=4, every request and kernel handshake answered in 1 cycle, exact beat counts.
  - Response: q_req_tile 0 then 1; kv_req_tile 0..3 twice; tiles_done=2; one done pulse; err=0.
- Zero tiles:
  - Stimulus: cfg_start with num=0.
  - Response: done the next cycle; k_ap_start and q_req_valid never assert.
- Simultaneous K/V beats:
  - Stimulus: k_beat and v_beat together for 16 cycles.
  - Response: LOAD_KV exits after 16 cycles. With v_beat lagging 5 cycles, it exits after 21.
- Stall timeout:
  - Stimulus: in LOAD_KV after 3 beats, stall_any=1 for 1024 cycles.
  - Response: err=1, err_code=1, all valids 0. err_clr -> IDLE.
- Overrun and early done:
  - Stimulus A: a 17th q_beat. Response: err_code=2.
  - Stimulus B: k_ap_done in LOAD_KV. Response: err_code=3.
  - Stimulus C: both in the same cycle. Response: err_code=2.
- Reset mid-run:
  - Stimulus: ap_rst_n low during DRAIN_O.
  - Response: all outputs 0 without waiting for a clock edge. A fresh cfg_start then completes normally.
